// File: rtl/mem_xfer_unit_if.sv
// Memory-side request/acknowledge bus between mem_xfer_unit and a variable-latency memory.
interface mem_xfer_unit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_xfer_unit.sv
// MAR/MDR owner running a bounded-wait request/acknowledge transfer with a
// variable-latency memory; pulses R to the control FSM when a transfer ends.
module mem_xfer_unit #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Buss,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic              memEn,
  input  logic              rw,
  mem_xfer_unit_if.master   mem,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic              busy,
  output logic              R,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  mar_d;
  logic [DATA_W-1:0]  mdr_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               terr_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      MAR         <= '0;
      MDR         <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      MAR         <= mar_d;
      MDR         <= mdr_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      timeout_err <= terr_d;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d = state_q;
    mar_d   = MAR;
    mdr_d   = MDR;
    we_d    = we_q;
    cnt_d   = cnt_q;
    terr_d  = timeout_err;
    case (state_q)
      S_IDLE: begin
        if (ldMAR) mar_d = Buss[ADDR_W-1:0];
        if (ldMDR) mdr_d = Buss;
        if (memEn) begin
          we_d    = rw;
          cnt_d   = '0;
          terr_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.mem_ack) begin
          if (!we_q) mdr_d = mem.mem_rdata;
          we_d    = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          // Bounded wait expired: finish the transfer with an error, MDR untouched
          terr_d  = 1'b1;
          we_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from the state register
  assign mem.mem_req   = (state_q == S_WAIT);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = MAR;
  assign mem.mem_wdata = MDR;
  assign busy          = (state_q == S_WAIT) || (state_q == S_DONE);
  assign R             = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_xfer_unit.sv
// Directed self-checking bench for mem_xfer_unit with hand-computed expectations.
module tb_mem_xfer_unit;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] Buss;
  logic              ldMAR, ldMDR, memEn, rw;
  logic [ADDR_W-1:0] MAR;
  logic [DATA_W-1:0] MDR;
  logic              busy, R, timeout_err;

  int checks = 0;
  int errors = 0;

  mem_xfer_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

  mem_xfer_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .Buss(Buss), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .memEn(memEn), .rw(rw), .mem(mif.master), .MAR(MAR), .MDR(MDR),
    .busy(busy), .R(R), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1; Buss = '0; ldMAR = 0; ldMDR = 0; memEn = 0; rw = 0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;

    #3;
    chk("rst_req",  32'(mif.mem_req), 32'd0);
    chk("rst_mar",  32'(MAR), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_R",    32'(R), 32'd0);

    // Bus loads then zero-wait write
    Buss = 16'h3000; ldMAR = 1; tick(); ldMAR = 0;
    chk("ld_mar", 32'(MAR), 32'h3000);
    Buss = 16'hBEEF; ldMDR = 1; tick(); ldMDR = 0;
    chk("ld_mdr", 32'(MDR), 32'hBEEF);
    memEn = 1; rw = 1; mif.mem_ack = 1; mif.mem_rdata = 16'h5555;
    tick(); memEn = 0;
    chk("wr_req",   32'(mif.mem_req), 32'd1);
    chk("wr_we",    32'(mif.mem_we), 32'd1);
    chk("wr_addr",  32'(mif.mem_addr), 32'h3000);
    chk("wr_wdata", 32'(mif.mem_wdata), 32'hBEEF);
    chk("wr_R0",    32'(R), 32'd0);
    tick(); mif.mem_ack = 0;
    chk("wr_R",     32'(R), 32'd1);
    chk("wr_req0",  32'(mif.mem_req), 32'd0);
    chk("wr_we0",   32'(mif.mem_we), 32'd0);
    chk("wr_mdr",   32'(MDR), 32'hBEEF);
    chk("wr_busyD", 32'(busy), 32'd1);
    tick();
    chk("wr_idleR", 32'(R), 32'd0);
    chk("wr_idleB", 32'(busy), 32'd0);

    // Read acknowledged on the 4th request cycle (back-to-back start)
    memEn = 1; rw = 0; mif.mem_rdata = 16'h1234;
    tick(); memEn = 0;
    for (int i = 0; i < 4; i++) begin
      chk("rd_req", 32'(mif.mem_req), 32'd1);
      chk("rd_we",  32'(mif.mem_we), 32'd0);
      if (i == 3) mif.mem_ack = 1;
      tick();
    end
    mif.mem_ack = 0;
    chk("rd_R",    32'(R), 32'd1);
    chk("rd_mdr",  32'(MDR), 32'h1234);
    chk("rd_req0", 32'(mif.mem_req), 32'd0);
    tick();
    chk("rd_busy", 32'(busy), 32'd0);

    // Timeout: never acknowledged
    memEn = 1; rw = 0; mif.mem_rdata = 16'h9999;
    tick(); memEn = 0;
    n = 0;
    for (int i = 0; i < 40 && mif.mem_req; i++) begin
      n++;
      tick();
    end
    chk("to_cycles", 32'(n), 32'(MAX_WAIT));
    chk("to_R",      32'(R), 32'd1);
    chk("to_err",    32'(timeout_err), 32'd1);
    chk("to_mdr",    32'(MDR), 32'h1234);
    tick();
    chk("to_sticky", 32'(timeout_err), 32'd1);
    chk("to_busy",   32'(busy), 32'd0);

    // Simultaneous ldMAR + memEn, then ignored inputs during WAIT
    Buss = 16'h4000; ldMAR = 1; memEn = 1; rw = 0;
    tick(); ldMAR = 0; memEn = 0;
    chk("sim_addr",  32'(mif.mem_addr), 32'h4000);
    chk("sim_req",   32'(mif.mem_req), 32'd1);
    chk("sim_errcl", 32'(timeout_err), 32'd0);
    Buss = 16'hFFFF; ldMAR = 1; ldMDR = 1; memEn = 1;
    tick(); ldMAR = 0; ldMDR = 0; memEn = 0;
    chk("ign_mar", 32'(MAR), 32'h4000);
    chk("ign_mdr", 32'(MDR), 32'h1234);
    chk("ign_req", 32'(mif.mem_req), 32'd1);
    mif.mem_ack = 1; mif.mem_rdata = 16'h0F0F;
    tick(); mif.mem_ack = 0;
    chk("ign_R",   32'(R), 32'd1);
    chk("ign_cap", 32'(MDR), 32'h0F0F);
    tick();
    chk("ign_idle", 32'(busy), 32'd0);
    tick();
    chk("ign_no2nd", 32'(mif.mem_req), 32'd0);

    // Reset in the middle of WAIT with ack high
    memEn = 1; rw = 0;
    tick(); memEn = 0;
    mif.mem_ack = 1; mif.mem_rdata = 16'hAAAA;
    chk("mr_req1", 32'(mif.mem_req), 32'd1);
    #2; reset = 1'b1; #1;
    chk("mr_req0", 32'(mif.mem_req), 32'd0);
    chk("mr_mdr",  32'(MDR), 32'd0);
    chk("mr_mar",  32'(MAR), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    tick();
    chk("mr_R",    32'(R), 32'd0);
    chk("mr_mdr2", 32'(MDR), 32'd0);
    reset = 1'b0; mif.mem_ack = 0;
    tick();
    chk("mr_R2",   32'(R), 32'd0);
    chk("mr_req2", 32'(mif.mem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_xfer_unit.md
Name: mem_xfer_unit

Overview:
- Parametrised successor to the datapath's memory data register.
- Owns both MAR and MDR and runs a request/acknowledge transaction with a variable-latency memory.
- Raises a one-cycle ready pulse (R) to the control FSM when a transfer finishes.
- Enforces a bounded wait: a timeout flags an error instead of hanging the controller.

Parameters:
- DATA_W, 16, width of MDR, Buss, and memory data.
- ADDR_W, 16, width of MAR and memory address; must satisfy ADDR_W <= DATA_W.
- MAX_WAIT, 15, maximum number of cycles mem_req stays high before timeout; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- Buss  in  DATA_W  processor bus.
- ldMAR  in  1  load MAR from Buss[ADDR_W-1:0].
- ldMDR  in  1  load MDR from Buss.
- memEn  in  1  start a memory transaction.
- rw  in  1  transaction type, sampled with memEn: 0 = read, 1 = write.
- mem_rdata  in  DATA_W  read data from memory.
- mem_ack  in  1  memory acknowledge, sampled only while mem_req=1.
- mem_req  out  1  request to memory, held until ack or timeout.
- mem_we  out  1  write enable to memory, valid while mem_req=1.
- mem_addr  out  ADDR_W  equals MAR.
- mem_wdata  out  DATA_W  equals MDR.
- MAR  out  ADDR_W  address register.
- MDR  out  DATA_W  data register.
- busy  out  1  high in WAIT and DONE states.
- R  out  1  one-cycle completion pulse.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset values (asynchronous, immediate on reset high): state=IDLE; MAR=0, MDR=0, mem_req=0, mem_we=0, busy=0, R=0, timeout_err=0, wait counter=0.
- States: IDLE, WAIT, DONE. All outputs are registered or decoded from state only; mem_addr and mem_wdata are direct copies of MAR and MDR.
- IDLE:
  - ldMAR loads MAR; ldMDR loads MDR.
  - memEn=1: latch rw into mem_we, clear the wait counter, clear timeout_err, go to WAIT.
  - A load and memEn may occur in the same cycle. The load takes effect at that edge, so the transaction uses the new MAR/MDR value.
- WAIT:
  - mem_req=1, busy=1. ldMAR, ldMDR and memEn are ignored; MAR and MDR hold, except for read capture.
  - mem_ack=1: on a read, MDR <= mem_rdata; on a write, MDR holds. Go to DONE.
  - mem_ack=0 and counter == MAX_WAIT-1: set timeout_err=1, go to DONE. MDR is unchanged on a timed-out read.
  - Otherwise: counter increments.
  - mem_req is therefore high for at most MAX_WAIT consecutive cycles.
- DONE: R=1, busy=1, mem_req=0; inputs ignored; go to IDLE unconditionally. R is high for exactly one cycle per transaction.
- Latency:
  - Zero-wait memory (ack in the first req cycle): memEn sampled at edge N, req high in cycle N+1, R high in cycle N+2, IDLE again in cycle N+3.
  - Each cycle of ack delay adds one cycle.
- Back-to-back: a new memEn is accepted in the first IDLE cycle after DONE.
- timeout_err stays high until the next accepted memEn or reset.
- Reset during WAIT: mem_req drops immediately. No MDR capture occurs even if mem_ack is high.
- mem_ack outside WAIT is ignored.
- Buss bits above ADDR_W are discarded on ldMAR.

Test Plan:
- Reset then idle:
  - Assert reset mid-cycle -> all outputs 0 without waiting for a clock edge.
  - Release reset -> state IDLE, busy=0.
- Bus loads, then write:
  - Buss=16'h3000 with ldMAR; Buss=16'hBEEF with ldMDR; then memEn, rw=1; ack in the first req cycle.
  - -> mem_addr=16'h3000, mem_wdata=16'hBEEF, mem_we=1 for one cycle; R pulses 2 cycles after memEn; MDR stays 16'hBEEF.
- Read with 3 wait cycles:
  - MAR=16'h3000; memEn, rw=0; ack on the 4th req cycle with mem_rdata=16'h1234.
  - -> mem_req high for 4 cycles, MDR=16'h1234, R pulse one cycle later, busy low afterwards.
- Timeout:
  - MAX_WAIT=15, read, never ack -> mem_req high exactly 15 cycles, then R pulse, timeout_err=1, MDR unchanged.
  - Next memEn -> timeout_err clears.
- Ignored inputs:
  - During WAIT, drive ldMAR/ldMDR with Buss=16'hFFFF and pulse memEn -> MAR/MDR unchanged, no second transaction.
  - Simultaneous ldMAR=16'h4000 and memEn in IDLE -> mem_addr=16'h4000 on the first req cycle.
- Reset mid-transaction:
  - Assert reset during WAIT with mem_ack=1, mem_rdata=16'hAAAA -> mem_req=0, MDR=0, no R pulse.
